// File: rtl/pixel_span_traversal.sv
// rtl/pixel_span_traversal.sv - walks a triangle bbox in raster order emitting LANES-wide masked spans
module pixel_span_traversal #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int LANES  = 4,
    parameter int ATTR_W = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(WIDTH)-1:0]  bbox_min_x,
    input  logic [$clog2(WIDTH)-1:0]  bbox_max_x,
    input  logic [$clog2(HEIGHT)-1:0] bbox_min_y,
    input  logic [$clog2(HEIGHT)-1:0] bbox_max_y,
    input  logic [ATTR_W-1:0]         attr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      abort,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic [LANES-1:0]          out_mask,
    output logic [ATTR_W-1:0]         out_attr,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);
    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int XW1 = XW + 1;
    localparam logic [XW-1:0] ALIGN_MASK = ~XW'(LANES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       min_x_q, min_x_d, max_x_q, max_x_d, cur_x_q, cur_x_d;
    logic [YW-1:0]       max_y_q, max_y_d, cur_y_q, cur_y_d;
    logic [ATTR_W-1:0]   attr_q, attr_d, out_attr_q, out_attr_d;
    logic [XW-1:0]       out_x_q, out_x_d;
    logic [YW-1:0]       out_y_q, out_y_d;
    logic [LANES-1:0]    out_mask_q, out_mask_d, span_mask;
    logic                out_last_q, out_last_d, out_valid_q, out_valid_d;
    logic                can_load, fire, row_end, last_span;

    // One extra bit on x so a span touching the right screen edge never wraps.
    always_comb begin
        span_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            span_mask[i] = (({1'b0, cur_x_q} + XW1'(i)) >= {1'b0, min_x_q}) &&
                           (({1'b0, cur_x_q} + XW1'(i)) <= {1'b0, max_x_q});
        end
        row_end   = ({1'b0, cur_x_q} + XW1'(LANES)) > {1'b0, max_x_q};
        last_span = row_end && (cur_y_q == max_y_q);
    end

    assign can_load = !out_valid_q || out_ready;
    assign fire     = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        max_y_d     = max_y_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        attr_d      = attr_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_mask_d  = out_mask_q;
        out_attr_d  = out_attr_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (fire) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    min_x_d = bbox_min_x;
                    max_x_d = bbox_max_x;
                    max_y_d = bbox_max_y;
                    attr_d  = attr;
                    cur_x_d = bbox_min_x & ALIGN_MASK;
                    cur_y_d = bbox_min_y;
                    if ((bbox_min_x <= bbox_max_x) && (bbox_min_y <= bbox_max_y)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (can_load) begin
                    out_x_d     = cur_x_q;
                    out_y_d     = cur_y_q;
                    out_mask_d  = span_mask;
                    out_attr_d  = attr_q;
                    out_last_d  = last_span;
                    out_valid_d = 1'b1;
                    if (row_end) begin
                        cur_x_d = min_x_q & ALIGN_MASK;
                        cur_y_d = cur_y_q + YW'(1);
                    end else begin
                        cur_x_d = cur_x_q + XW'(LANES);
                    end
                    if (last_span) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            min_x_q     <= '0;
            max_x_q     <= '0;
            max_y_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            attr_q      <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_mask_q  <= '0;
            out_attr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            max_y_q     <= max_y_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            attr_q      <= attr_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_mask_q  <= out_mask_d;
            out_attr_q  <= out_attr_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE) || out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_mask  = out_mask_q;
    assign out_attr  = out_attr_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_pixel_span_traversal.sv
// tb/tb_pixel_span_traversal.sv - directed bench for pixel_span_traversal (LANES=4 and LANES=1)
module tb_pixel_span_traversal;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [8:0]   bbox_min_x = '0, bbox_max_x = '0;
    logic [7:0]   bbox_min_y = '0, bbox_max_y = '0;
    logic [255:0] attr = '0;
    logic         in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;

    logic         in_ready4, out_last4, out_valid4, busy4;
    logic [8:0]   out_x4;
    logic [7:0]   out_y4;
    logic [3:0]   out_mask4;
    logic [255:0] out_attr4;
    logic         in_ready1, out_last1, out_valid1, busy1;
    logic [8:0]   out_x1;
    logic [7:0]   out_y1;
    logic [0:0]   out_mask1;
    logic [255:0] out_attr1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0]   q4x[$], q1x[$];
    logic [7:0]   q4y[$], q1y[$];
    logic [3:0]   q4m[$];
    logic [0:0]   q1m[$];
    logic         q4l[$], q1l[$];
    logic [255:0] q4a[$];
    int           q4c[$];

    localparam logic [255:0] ATTR_A = {8{32'hDEADBEEF}};
    localparam logic [255:0] ATTR_B = {8{32'h12345678}};
    localparam logic [255:0] ATTR_C = {8{32'hA5A5C3C3}};

    pixel_span_traversal #(.WIDTH(320), .HEIGHT(240), .LANES(4), .ATTR_W(256)) dut4 (
        .clk(clk), .rst(rst),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .attr(attr), .in_valid(in_valid), .in_ready(in_ready4), .abort(abort),
        .out_x(out_x4), .out_y(out_y4), .out_mask(out_mask4), .out_attr(out_attr4),
        .out_last(out_last4), .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4)
    );

    pixel_span_traversal #(.WIDTH(320), .HEIGHT(240), .LANES(1), .ATTR_W(256)) dut1 (
        .clk(clk), .rst(rst),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .attr(attr), .in_valid(in_valid), .in_ready(in_ready1), .abort(abort),
        .out_x(out_x1), .out_y(out_y1), .out_mask(out_mask1), .out_attr(out_attr1),
        .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every span that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready) begin
            q4x.push_back(out_x4); q4y.push_back(out_y4); q4m.push_back(out_mask4);
            q4l.push_back(out_last4); q4a.push_back(out_attr4); q4c.push_back(cyc);
        end
        if (!rst && out_valid1 && out_ready) begin
            q1x.push_back(out_x1); q1y.push_back(out_y1); q1m.push_back(out_mask1);
            q1l.push_back(out_last1);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_q();
        q4x.delete(); q4y.delete(); q4m.delete(); q4l.delete(); q4a.delete(); q4c.delete();
        q1x.delete(); q1y.delete(); q1m.delete(); q1l.delete();
    endtask

    task automatic offer(input int mnx, input int mxx, input int mny, input int mxy,
                         input logic [255:0] a);
        bbox_min_x = 9'(mnx); bbox_max_x = 9'(mxx);
        bbox_min_y = 8'(mny); bbox_max_y = 8'(mxy);
        attr = a;
        in_valid = 1'b1;
        chk("accept_ready", in_ready4, 1);
        step();
        in_valid = 1'b0;
        attr = '0;
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        int n = 0;
        while ((sel ? busy1 : busy4) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", sel ? busy1 : busy4, 0);
    endtask

    initial begin
        int ex[4] = '{4, 8, 4, 8};
        int ey[4] = '{2, 2, 3, 3};
        logic [3:0] em[4] = '{4'b1110, 4'b0111, 4'b1110, 4'b0111};

        step(); step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", in_ready4, 1);
        chk("rst_out_valid", out_valid4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_out_x", out_x4, 0);
        chk("rst_out_mask", out_mask4, 0);
        chk("rst_out_attr", out_attr4, 0);

        // Basic 2x2-span triangle, streaming
        clear_q();
        offer(5, 10, 2, 3, ATTR_A);
        wait_idle(0, 50);
        chk("t1_count", q4x.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_x%0d", k), q4x[k], ex[k]);
            chk($sformatf("t1_y%0d", k), q4y[k], ey[k]);
            chk($sformatf("t1_mask%0d", k), q4m[k], em[k]);
            chk($sformatf("t1_last%0d", k), q4l[k], k == 3);
            chk($sformatf("t1_attr%0d", k), q4a[k], ATTR_A);
        end
        for (int k = 0; k < 3; k++) chk($sformatf("t1_b2b%0d", k), q4c[k+1] - q4c[k], 1);

        // Full screen-width row, no wrap at the right edge
        clear_q();
        offer(0, 319, 0, 0, ATTR_B);
        wait_idle(0, 200);
        chk("t2_count", q4x.size(), 80);
        for (int k = 0; k < 80; k++) begin
            chk($sformatf("t2_x%0d", k), q4x[k], 4 * k);
            chk($sformatf("t2_mask%0d", k), q4m[k], 4'b1111);
            chk($sformatf("t2_last%0d", k), q4l[k], k == 79);
        end

        // Degenerate bbox
        clear_q();
        offer(7, 3, 0, 0, ATTR_C);
        for (int k = 0; k < 3; k++) begin
            chk("t3_in_ready", in_ready4, 1);
            chk("t3_busy", busy4, 0);
            step();
        end
        chk("t3_count", q4x.size(), 0);

        // Backpressure mid-row
        clear_q();
        offer(0, 15, 0, 1, ATTR_C);
        step(); step();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_valid", out_valid4, 1);
            chk("t4_hold_x", out_x4, 4);
            chk("t4_hold_y", out_y4, 0);
            chk("t4_hold_mask", out_mask4, 4'b1111);
            chk("t4_hold_attr", out_attr4, ATTR_C);
            chk("t4_hold_count", q4x.size(), 1);
        end
        out_ready = 1'b1;
        wait_idle(0, 50);
        chk("t4_count", q4x.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_x%0d", k), q4x[k], 4 * (k % 4));
            chk($sformatf("t4_y%0d", k), q4y[k], k / 4);
            chk($sformatf("t4_last%0d", k), q4l[k], k == 7);
        end

        // Abort with the second span pending under backpressure
        clear_q();
        offer(0, 11, 0, 1, ATTR_B);
        step(); step();
        out_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_in_ready", in_ready4, 1);
        chk("t5_pend_valid", out_valid4, 1);
        chk("t5_pend_x", out_x4, 4);
        chk("t5_pend_last", out_last4, 0);
        step(); step();
        chk("t5_still_x", out_x4, 4);
        out_ready = 1'b1;
        wait_idle(0, 20);
        chk("t5_count", q4x.size(), 2);
        chk("t5_x1", q4x[1], 4);
        chk("t5_last1", q4l[1], 0);
        clear_q();
        offer(5, 10, 2, 3, ATTR_A);
        wait_idle(0, 50);
        chk("t5_next_count", q4x.size(), 4);
        chk("t5_next_x0", q4x[0], 4);
        chk("t5_next_y0", q4y[0], 2);
        chk("t5_next_mask0", q4m[0], 4'b1110);
        chk("t5_next_attr0", q4a[0], ATTR_A);

        // Reset mid-triangle, then single-lane traversal
        offer(0, 319, 0, 9, ATTR_C);
        step(); step(); step();
        chk("t6_pre_valid", out_valid4, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid4", out_valid4, 0);
        chk("t6_rst_ready4", in_ready4, 1);
        chk("t6_rst_busy4", busy4, 0);
        chk("t6_rst_valid1", out_valid1, 0);
        step();
        rst = 1'b0;
        step();
        chk("t6_post_valid4", out_valid4, 0);
        chk("t6_post_ready1", in_ready1, 1);
        clear_q();
        offer(3, 5, 1, 2, ATTR_A);
        wait_idle(1, 50);
        chk("t6_count", q1x.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6_x%0d", k), q1x[k], 3 + (k % 3));
            chk($sformatf("t6_y%0d", k), q1y[k], 1 + (k / 3));
            chk($sformatf("t6_mask%0d", k), q1m[k], 1);
            chk($sformatf("t6_last%0d", k), q1l[k], k == 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
